// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity-mode constants and FSM encodings for the UART receive-frame checker
package uart_pkg;

    typedef logic [1:0] par_mode_t;

    localparam par_mode_t PAR_NONE = 2'b00;
    localparam par_mode_t PAR_EVEN = 2'b01;
    localparam par_mode_t PAR_ODD  = 2'b10;
    localparam par_mode_t PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        RXC_IDLE   = 3'd0,
        RXC_DATA   = 3'd1,
        RXC_PARITY = 3'd2,
        RXC_STOP   = 3'd3,
        RXC_DONE   = 3'd4
    } rxc_state_t;

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// rtl/uart_rx_frame_check_if.sv - signal bundle between the RX front end and the frame checker
// master: front end / bench (drives frame_start, bit_valid, rx_bit, parity_mode, cnt_clear)
// slave : frame checker (drives busy, data_out, data_valid, parity_err, framing_err, counters)
interface uart_rx_frame_check_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    import uart_pkg::*;

    logic                  frame_start;
    logic                  bit_valid;
    logic                  rx_bit;
    par_mode_t             parity_mode;
    logic                  cnt_clear;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  parity_err;
    logic                  framing_err;
    logic [CNT_WIDTH-1:0]  parity_err_cnt;
    logic [CNT_WIDTH-1:0]  frame_err_cnt;

    modport master (
        output frame_start, bit_valid, rx_bit, parity_mode, cnt_clear,
        input  busy, data_out, data_valid, parity_err, framing_err,
               parity_err_cnt, frame_err_cnt
    );

    modport slave (
        input  frame_start, bit_valid, rx_bit, parity_mode, cnt_clear,
        output busy, data_out, data_valid, parity_err, framing_err,
               parity_err_cnt, frame_err_cnt
    );

endinterface

// File: rtl/uart_sat_counter.sv
// rtl/uart_sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst (async, active-high), clear, inc, count[WIDTH-1:0]
// clear together with inc yields 1 so a same-cycle event is never lost.
module uart_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// rtl/uart_rx_frame_check.sv - UART receive-frame assembler with parity/stop checking and error counters
// Ports: clk, rst (async, active-high), bus (uart_rx_frame_check_if.slave)
// Inputs  : frame_start, bit_valid, rx_bit, parity_mode, cnt_clear
// Outputs : busy, data_out, data_valid, parity_err, framing_err, parity_err_cnt, frame_err_cnt
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input logic                    clk,
    input logic                    rst,
    uart_rx_frame_check_if.slave   bus
);
    import uart_pkg::*;

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    rxc_state_t            state_q,    state_d;
    par_mode_t             mode_q,     mode_d;
    logic [BCW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_acc_q,  par_acc_d;
    logic                  perr_run_q, perr_run_d;
    logic                  ferr_run_q, ferr_run_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic                  perr_q,     perr_d;
    logic                  ferr_q,     ferr_d;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        perr_run_d = perr_run_q;
        ferr_run_d = ferr_run_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;

        unique case (state_q)
            RXC_IDLE: begin
                // A bit_valid in the same cycle belongs to the start bit, not the data.
                if (bus.frame_start) begin
                    state_d    = RXC_DATA;
                    mode_d     = bus.parity_mode;
                    bit_cnt_d  = '0;
                    par_acc_d  = 1'b0;
                    perr_run_d = 1'b0;
                    ferr_run_d = 1'b0;
                end
            end
            RXC_DATA: begin
                if (bus.bit_valid) begin
                    // LSB arrives first, so shifting right from the MSB leaves it at bit 0.
                    shift_d   = {bus.rx_bit, shift_q[DATA_WIDTH-1:1]};
                    par_acc_d = par_acc_q ^ bus.rx_bit;
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (mode_q == PAR_NONE) ? RXC_STOP : RXC_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            RXC_PARITY: begin
                if (bus.bit_valid) begin
                    unique case (mode_q)
                        PAR_EVEN: perr_run_d = (bus.rx_bit != par_acc_q);
                        PAR_ODD:  perr_run_d = (bus.rx_bit != ~par_acc_q);
                        PAR_MARK: perr_run_d = (bus.rx_bit != 1'b1);
                        default:  perr_run_d = 1'b0;
                    endcase
                    state_d = RXC_STOP;
                end
            end
            RXC_STOP: begin
                if (bus.bit_valid) begin
                    // A bad stop bit is only flagged; the remaining stop bits are still consumed.
                    ferr_run_d = ferr_run_q | ~bus.rx_bit;
                    if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
                        state_d = RXC_DONE;
                        data_d  = shift_q;
                        perr_d  = perr_run_q;
                        ferr_d  = ferr_run_q | ~bus.rx_bit;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            RXC_DONE: begin
                state_d = RXC_IDLE;
            end
            default: begin
                state_d = RXC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RXC_IDLE;
            mode_q     <= PAR_NONE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            perr_run_q <= 1'b0;
            ferr_run_q <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            perr_run_q <= perr_run_d;
            ferr_run_q <= ferr_run_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.busy        = (state_q != RXC_IDLE) && (state_q != RXC_DONE);
    assign bus.data_valid  = (state_q == RXC_DONE);
    assign bus.data_out    = data_q;
    assign bus.parity_err  = perr_q;
    assign bus.framing_err = ferr_q;

    uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_parity_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.cnt_clear),
        .inc   (bus.data_valid & perr_q),
        .count (bus.parity_err_cnt)
    );

    uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.cnt_clear),
        .inc   (bus.data_valid & ferr_q),
        .count (bus.frame_err_cnt)
    );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb/tb_uart_rx_frame_check.sv - self-checking bench for uart_rx_frame_check (8-bit/1-stop and 9-bit/2-stop/2-bit-counter instances)
module tb_uart_rx_frame_check;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_frame_check_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) ifa ();
    uart_rx_frame_check_if #(.DATA_WIDTH(9), .CNT_WIDTH(2)) ifb ();

    uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    uart_rx_frame_check #(.DATA_WIDTH(9), .STOP_BITS(2), .CNT_WIDTH(2)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    typedef struct {
        logic       dv;
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       early;
        logic       busy_bad;
        logic       busy_done;
        logic       dv_after;
        int         pc;
        int         fc;
    } obs_t;

    typedef struct {
        int         sel;
        logic [1:0] mode;
        logic [8:0] data;
        logic       pb;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_p[2];
    int cnt_f[2];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drv(input int sel, input logic fs, input logic bv, input logic rb,
                       input logic [1:0] pm, input logic clr);
        if (sel == 0) begin
            ifa.frame_start = fs; ifa.bit_valid = bv; ifa.rx_bit = rb;
            ifa.parity_mode = pm; ifa.cnt_clear = clr;
        end else begin
            ifb.frame_start = fs; ifb.bit_valid = bv; ifb.rx_bit = rb;
            ifb.parity_mode = pm; ifb.cnt_clear = clr;
        end
    endtask

    function automatic logic rd_dv(input int sel);
        return (sel != 0) ? ifb.data_valid : ifa.data_valid;
    endfunction
    function automatic logic rd_busy(input int sel);
        return (sel != 0) ? ifb.busy : ifa.busy;
    endfunction
    function automatic logic [8:0] rd_data(input int sel);
        return (sel != 0) ? ifb.data_out : {1'b0, ifa.data_out};
    endfunction
    function automatic logic rd_pe(input int sel);
        return (sel != 0) ? ifb.parity_err : ifa.parity_err;
    endfunction
    function automatic logic rd_fe(input int sel);
        return (sel != 0) ? ifb.framing_err : ifa.framing_err;
    endfunction
    function automatic int rd_pc(input int sel);
        return (sel != 0) ? int'(ifb.parity_err_cnt) : int'(ifa.parity_err_cnt);
    endfunction
    function automatic int rd_fc(input int sel);
        return (sel != 0) ? int'(ifb.frame_err_cnt) : int'(ifa.frame_err_cnt);
    endfunction

    // Reference model: parity rule from the count of ones, framing from any zero stop bit.
    function automatic logic model_perr(input int sel, input logic [1:0] mode,
                                        input logic [8:0] data, input logic pb);
        int ones = 0;
        int nd   = (sel != 0) ? 9 : 8;
        for (int i = 0; i < nd; i++) ones += int'(data[i]);
        case (mode)
            2'b00:   return 1'b0;
            2'b01:   return pb != ((ones % 2) == 1);
            2'b10:   return pb != ((ones % 2) == 0);
            default: return pb != 1'b1;
        endcase
    endfunction

    function automatic logic model_ferr(input int sel, input logic [1:0] stops);
        int ns = (sel != 0) ? 2 : 1;
        for (int i = 0; i < ns; i++) if (stops[i] == 1'b0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic sample(input int sel, inout obs_t o);
        if (rd_dv(sel))    o.early    = 1'b1;
        if (!rd_busy(sel)) o.busy_bad = 1'b1;
    endtask

    task automatic send_frame(input int sel, input logic [1:0] mode, input logic [8:0] data,
                              input logic pb, input logic [1:0] stops, input int gap,
                              input logic [1:0] mode_mid, input logic fs_stop,
                              input logic fs_bv, input logic clr, output obs_t o);
        logic bits[$];
        int   nd = (sel != 0) ? 9 : 8;
        int   ns = (sel != 0) ? 2 : 1;
        int   first_stop;
        o.dv = 0; o.data = '0; o.pe = 0; o.fe = 0; o.early = 0;
        o.busy_bad = 0; o.busy_done = 0; o.dv_after = 0; o.pc = 0; o.fc = 0;
        for (int i = 0; i < nd; i++) bits.push_back(data[i]);
        if (mode != PAR_NONE) bits.push_back(pb);
        first_stop = bits.size();
        for (int i = 0; i < ns; i++) bits.push_back(stops[i]);
        if (fs_bv) begin
            drv(sel, 1'b0, 1'b1, 1'($urandom), mode, 1'b0);
            @(negedge clk);
        end
        drv(sel, 1'b1, fs_bv, 1'($urandom), mode, 1'b0);
        @(negedge clk);
        drv(sel, 1'b0, 1'b0, 1'b0, mode_mid, 1'b0);
        for (int i = 0; i < bits.size(); i++) begin
            int g = $urandom_range(0, gap);
            for (int j = 0; j < g; j++) begin
                sample(sel, o);
                @(negedge clk);
            end
            sample(sel, o);
            drv(sel, fs_stop && (i >= first_stop), 1'b1, bits[i], mode_mid, 1'b0);
            @(negedge clk);
            drv(sel, 1'b0, 1'b0, 1'b0, mode_mid, 1'b0);
        end
        o.dv        = rd_dv(sel);
        o.data      = rd_data(sel);
        o.pe        = rd_pe(sel);
        o.fe        = rd_fe(sel);
        o.busy_done = rd_busy(sel);
        drv(sel, 1'b0, 1'b0, 1'b0, mode_mid, clr);
        @(negedge clk);
        drv(sel, 1'b0, 1'b0, 1'b0, mode_mid, 1'b0);
        o.dv_after = rd_dv(sel);
        o.pc       = rd_pc(sel);
        o.fc       = rd_fc(sel);
    endtask

    task automatic check_frame(input string tag, input int sel, input logic [8:0] exp_data,
                               input logic exp_pe, input logic exp_fe, input logic clr,
                               input obs_t o);
        int         mx   = (sel != 0) ? 3 : 255;
        logic [8:0] mask = (sel != 0) ? 9'h1FF : 9'h0FF;
        chk({tag, " data_valid"},  o.dv, 1);
        chk({tag, " data_out"},    o.data, exp_data & mask);
        chk({tag, " parity_err"},  o.pe, exp_pe);
        chk({tag, " framing_err"}, o.fe, exp_fe);
        chk({tag, " early_valid"}, o.early, 0);
        chk({tag, " busy_frame"},  o.busy_bad, 0);
        chk({tag, " busy_done"},   o.busy_done, 0);
        chk({tag, " pulse_width"}, o.dv_after, 0);
        if (clr) begin
            cnt_p[sel] = exp_pe ? 1 : 0;
            cnt_f[sel] = exp_fe ? 1 : 0;
        end else begin
            if (exp_pe && cnt_p[sel] < mx) cnt_p[sel]++;
            if (exp_fe && cnt_f[sel] < mx) cnt_f[sel]++;
        end
        chk({tag, " parity_err_cnt"}, o.pc, cnt_p[sel]);
        chk({tag, " frame_err_cnt"},  o.fc, cnt_f[sel]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        obs_t o;
        int   t4_exp[5];

        tbl[0] = '{0, PAR_EVEN, 9'h0A5, 1'b0, 2'b01, 9'h0A5, 1'b0, 1'b0};
        tbl[1] = '{0, PAR_ODD,  9'h000, 1'b0, 2'b01, 9'h000, 1'b1, 1'b0};
        tbl[2] = '{1, PAR_NONE, 9'h03C, 1'b0, 2'b01, 9'h03C, 1'b0, 1'b1};
        tbl[3] = '{0, PAR_MARK, 9'h05A, 1'b1, 2'b01, 9'h05A, 1'b0, 1'b0};
        tbl[4] = '{0, PAR_MARK, 9'h03C, 1'b0, 2'b00, 9'h03C, 1'b1, 1'b1};
        tbl[5] = '{1, PAR_ODD,  9'h1FF, 1'b0, 2'b11, 9'h1FF, 1'b0, 1'b0};
        tbl[6] = '{1, PAR_EVEN, 9'h101, 1'b0, 2'b11, 9'h101, 1'b0, 1'b0};
        tbl[7] = '{0, PAR_NONE, 9'h0FF, 1'b1, 2'b00, 9'h0FF, 1'b0, 1'b1};
        tbl[8] = '{1, PAR_EVEN, 9'h0AA, 1'b1, 2'b10, 9'h0AA, 1'b1, 1'b1};
        tbl[9] = '{0, PAR_ODD,  9'h001, 1'b0, 2'b01, 9'h001, 1'b0, 1'b0};
        t4_exp = '{1, 2, 3, 3, 3};

        drv(0, 1'b0, 1'b0, 1'b0, PAR_NONE, 1'b0);
        drv(1, 1'b0, 1'b0, 1'b0, PAR_NONE, 1'b0);
        cnt_p = '{0, 0};
        cnt_f = '{0, 0};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset%0d busy", s),        rd_busy(s), 0);
            chk($sformatf("reset%0d data_valid", s),  rd_dv(s), 0);
            chk($sformatf("reset%0d data_out", s),    rd_data(s), 0);
            chk($sformatf("reset%0d errs", s),        {rd_pe(s), rd_fe(s)}, 0);
            chk($sformatf("reset%0d counters", s),    rd_pc(s) + rd_fc(s), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors (T1..T3 and further parity/stop combinations).
        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].sel, tbl[i].mode, tbl[i].data, tbl[i].pb, tbl[i].stops, 1,
                       ~tbl[i].mode, 1'b0, 1'b0, 1'b0, o);
            check_frame($sformatf("vec%0d", i), tbl[i].sel, tbl[i].exp_data,
                        tbl[i].exp_pe, tbl[i].exp_fe, 1'b0, o);
        end

        // T4: cnt_clear alone, then saturation of the 2-bit counter, then clear with increment.
        drv(1, 1'b0, 1'b0, 1'b0, PAR_NONE, 1'b1);
        @(negedge clk);
        drv(1, 1'b0, 1'b0, 1'b0, PAR_NONE, 1'b0);
        chk("T4 clear_alone parity_cnt", rd_pc(1), 0);
        chk("T4 clear_alone frame_cnt",  rd_fc(1), 0);
        cnt_p[1] = 0;
        cnt_f[1] = 0;
        for (int k = 0; k < 5; k++) begin
            send_frame(1, PAR_EVEN, 9'h003, 1'b1, 2'b11, 0, PAR_EVEN, 1'b0, 1'b0, 1'b0, o);
            check_frame($sformatf("T4 bad%0d", k), 1, 9'h003, 1'b1, 1'b0, 1'b0, o);
            chk($sformatf("T4 sat%0d", k), o.pc, t4_exp[k]);
        end
        send_frame(1, PAR_EVEN, 9'h003, 1'b1, 2'b11, 0, PAR_EVEN, 1'b0, 1'b0, 1'b1, o);
        check_frame("T4 clear_inc", 1, 9'h003, 1'b1, 1'b0, 1'b1, o);
        chk("T4 clear_inc count", o.pc, 1);

        // T5: reset after four data bits discards the frame.
        drv(0, 1'b1, 1'b0, 1'b0, PAR_MARK, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drv(0, 1'b0, 1'b1, 1'b1, PAR_MARK, 1'b0);
            @(negedge clk);
        end
        drv(0, 1'b0, 1'b0, 1'b0, PAR_MARK, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("T5 reset busy",     rd_busy(0), 0);
        chk("T5 reset counters", rd_pc(0) + rd_fc(0) + rd_pc(1) + rd_fc(1), 0);
        cnt_p = '{0, 0};
        cnt_f = '{0, 0};
        rst = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (rd_dv(0)) seen = 1'b1;
            end
            chk("T5 no_pulse_after_abort", seen, 0);
        end
        send_frame(0, PAR_MARK, 9'h081, 1'b1, 2'b01, 1, PAR_MARK, 1'b0, 1'b0, 1'b0, o);
        check_frame("T5 clean", 0, 9'h081, 1'b0, 1'b0, 1'b0, o);

        // T6: mode changed even->odd mid-frame, frame_start during STOP ignored.
        send_frame(1, PAR_EVEN, 9'h0F3, 1'b0, 2'b11, 1, PAR_ODD, 1'b1, 1'b0, 1'b0, o);
        check_frame("T6 mode_switch", 1, 9'h0F3, 1'b0, 1'b0, 1'b0, o);

        // Randomized frames against the reference model.
        for (int k = 0; k < 60; k++) begin
            int         sel   = $urandom_range(0, 1);
            logic [1:0] mode  = 2'($urandom_range(0, 3));
            logic [8:0] data  = 9'($urandom);
            logic       pb    = 1'($urandom);
            logic [1:0] stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            logic       clr   = ($urandom_range(0, 9) == 0);
            logic       fss   = 1'($urandom);
            logic       fsb   = 1'($urandom);
            send_frame(sel, mode, data, pb, stops, 3, 2'($urandom), fss, fsb, clr, o);
            check_frame($sformatf("rand%0d", k), sel, data,
                        model_perr(sel, mode, data, pb), model_ferr(sel, stops), clr, o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
